if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  in  1  synchronous, active-high; sampled on rising clk edge.
REQ-003 SHALL: Stall  in  1  load-use/jr hazard hold from hazard detection.
REQ-004 SHALL: PCSrc  in  3  next-PC select: 000 seq, 001 branch, 010 jr, 011 jump, 100 ILLOP, 101 XADR, 110/111 seq.
REQ-005 SHALL: BranchTarget  in  32  branch target address.
REQ-006 SHALL: JumpTarget  in  32  j/jal target address.
REQ-007 SHALL: RegTarget  in  32  jr/jalr register value.
REQ-008 SHALL: IF_Flush  in  1  external request to squash the instruction entering IF/ID.
REQ-009 SHALL: imem_rdata  in  32  instruction word for address PC.
REQ-010 SHALL: imem_ready  in  1  imem_rdata valid this cycle.
REQ-011 SHALL: PC  out  32  current fetch address; also drives imem address.
REQ-012 SHALL: IF_ID_Instruction  out  32  latched instruction.
REQ-013 SHALL: IF_ID_PC_Plus4  out  32  latched PC+4 of that instruction.
REQ-014 SHALL: IF_ID_Valid  out  1  1 = real instruction, 0 = bubble.
REQ-015 SHALL: BubbleCount  out  16  count of cycles IF/ID loaded a bubble.

Function
REQ-016 SHALL: PC+4 computed modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
REQ-017 SHALL: every PC load forces PC[1:0] = 00.
REQ-018 SHALL: exception (PCSrc 100/101) priority over Stall: PC <= 0x80000004 (100) or 0x80000008 (101); IF/ID <= bubble.
REQ-019 SHALL: else if Stall=1: PC, IF/ID and BubbleCount hold; IF_Flush and imem_ready ignored.
REQ-020 SHALL: else if PCSrc in {001,010,011}: PC <= selected target regardless of imem_ready; IF/ID <= bubble (wrong-path fetch discarded).
REQ-021 SHALL: else (sequential) if imem_ready=0: PC holds; IF/ID <= bubble.
REQ-022 SHALL: else (sequential, imem_ready=1): PC <= PC+4; IF/ID <= {imem_rdata, PC+4, Valid=1} unless IF_Flush=1, which loads bubble while PC still advances.
REQ-023 SHALL: bubble means IF_ID_Instruction=0x00000000 (nop), IF_ID_PC_Plus4=0, IF_ID_Valid=0.
REQ-024 SHALL: BubbleCount increments by 1 on every non-reset cycle that loads a bubble, saturating at 0xFFFF.
REQ-025 SHALL: fetch latency one cycle: instruction at address A with imem_ready=1 appears on IF/ID outputs the cycle after PC=A.
REQ-026 SHALL: outputs are registered; no combinational path from inputs to any output.

Reset
REQ-027 SHALL: reset=1 sets PC=0x80000000, IF/ID to bubble, BubbleCount=0, overriding all other inputs.
REQ-028 SHALL: reset asserted mid-stall or mid-wait discards held state; first cycle after release fetches 0x80000000.
REQ-029 SHALL: reset cycle itself does not increment BubbleCount.

Verification
REQ-030 SHALL: after reset, imem_ready=1, PCSrc=000, rdata=0x20080001 -> PC 0x80000000,0x80000004; IF_ID_Instruction=0x20080001, PC_Plus4=0x80000004, Valid=1.
REQ-031 SHALL: Stall=1 two cycles with PCSrc=000 -> PC and IF/ID unchanged, BubbleCount unchanged; release resumes at PC+4.
REQ-032 SHALL: PCSrc=010, RegTarget=0x00400013, Stall=0 -> next PC=0x00400010, Valid=0, BubbleCount+1.
REQ-033 SHALL: PCSrc=100 with Stall=1 -> PC=0x80000004, Valid=0.
REQ-034 SHALL: imem_ready=0 three cycles -> PC held, three bubbles, BubbleCount+3; IF_Flush=1 with ready=1 -> PC advances, Valid=0.
REQ-035 SHALL: BubbleCount preset to 0xFFFF by 65535 bubble cycles, one more bubble -> stays 0xFFFF; PC=0xFFFFFFFC sequential -> PC=0x00000000.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register, plus a saturating count of bubbles loaded into IF/ID.
module if_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic [2:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] RegTarget,
    input  logic        IF_Flush,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PC_Plus4,
    output logic        IF_ID_Valid,
    output logic [15:0] BubbleCount
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam logic [2:0] SRC_SEQ    = 3'b000;
    localparam logic [2:0] SRC_BRANCH = 3'b001;
    localparam logic [2:0] SRC_JR     = 3'b010;
    localparam logic [2:0] SRC_JUMP   = 3'b011;
    localparam logic [2:0] SRC_ILLOP  = 3'b100;
    localparam logic [2:0] SRC_XADR   = 3'b101;

    localparam logic [31:0] PC_RESET = 32'h8000_0000;
    localparam logic [31:0] PC_ILLOP = 32'h8000_0004;
    localparam logic [31:0] PC_XADR  = 32'h8000_0008;

    localparam if_id_t BUBBLE = '{instr: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

    logic [31:0] pc_q, pc_d;
    if_id_t      if_id_q, if_id_d;
    logic [15:0] bcnt_q, bcnt_d;

    logic [31:0] pc_plus4;
    logic        is_exc;
    logic        is_redirect;
    logic        load_bubble;
    logic [31:0] redirect_tgt;

    assign pc_plus4 = pc_q + 32'd4;

    // Classify the PC source; 110/111 fall through to sequential fetch.
    always_comb begin
        is_exc       = 1'b0;
        is_redirect  = 1'b0;
        redirect_tgt = pc_plus4;
        unique case (PCSrc)
            SRC_ILLOP: begin
                is_exc       = 1'b1;
                redirect_tgt = PC_ILLOP;
            end
            SRC_XADR: begin
                is_exc       = 1'b1;
                redirect_tgt = PC_XADR;
            end
            SRC_BRANCH: begin
                is_redirect  = 1'b1;
                redirect_tgt = BranchTarget;
            end
            SRC_JR: begin
                is_redirect  = 1'b1;
                redirect_tgt = RegTarget;
            end
            SRC_JUMP: begin
                is_redirect  = 1'b1;
                redirect_tgt = JumpTarget;
            end
            default: begin
                is_exc       = 1'b0;
                is_redirect  = 1'b0;
                redirect_tgt = pc_plus4;
            end
        endcase
    end

    // Next PC and IF/ID contents; exceptions beat stalls, stalls beat redirects.
    always_comb begin
        pc_d        = pc_q;
        if_id_d     = if_id_q;
        load_bubble = 1'b0;
        if (is_exc) begin
            pc_d        = {redirect_tgt[31:2], 2'b00};
            load_bubble = 1'b1;
        end else if (Stall) begin
            pc_d        = pc_q;
            load_bubble = 1'b0;
        end else if (is_redirect) begin
            pc_d        = {redirect_tgt[31:2], 2'b00};
            load_bubble = 1'b1;
        end else if (!imem_ready) begin
            pc_d        = pc_q;
            load_bubble = 1'b1;
        end else begin
            pc_d        = {pc_plus4[31:2], 2'b00};
            load_bubble = IF_Flush;
            if (!IF_Flush) begin
                if_id_d = '{instr: imem_rdata, pc_plus4: pc_plus4, valid: 1'b1};
            end
        end
        if (load_bubble) begin
            if_id_d = BUBBLE;
        end
    end

    // Bubble counter saturates so long runs never wrap to a misleading value.
    always_comb begin
        bcnt_d = bcnt_q;
        if (load_bubble && (bcnt_q != 16'hFFFF)) begin
            bcnt_d = bcnt_q + 16'd1;
        end
    end

    // State registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            if_id_q <= BUBBLE;
            bcnt_q  <= 16'h0;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign PC                = pc_q;
    assign IF_ID_Instruction = if_id_q.instr;
    assign IF_ID_PC_Plus4    = if_id_q.pc_plus4;
    assign IF_ID_Valid       = if_id_q.valid;
    assign BubbleCount       = bcnt_q;

    logic unused_src;
    assign unused_src = ^{SRC_SEQ};

endmodule
